bcd_to_bin_seq: RTL and testbench

//  Sequential packed-BCD to unsigned binary converter using reverse double-dabble: one shift per clock.

---
 rtl/bcd_to_bin_seq.sv | 118 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// One right shift per clock with parallel per-digit correction; start/busy/done handshake.
module bcd_to_bin_seq #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned BIN_W = 14,
  parameter int unsigned CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [4*NDIG-1:0]    bcd_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [BIN_W-1:0]     result
);

  localparam int unsigned BCD_W  = 4 * NDIG;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [WORK_W-1:0]   work, work_nxt, shifted;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                busy_nxt, done_nxt, err_nxt;
  logic [BIN_W-1:0]    result_nxt;

  // True when every 4-bit field of the packed BCD word is a decimal digit.
  function automatic logic digits_ok(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (v[4*k +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // One reverse double-dabble step: shift right, then pull each digit field >= 8 down by 3.
  always_comb begin
    shifted = work >> 1;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (shifted[BIN_W + 4*k +: 4] >= 4'd8) begin
        shifted[BIN_W + 4*k +: 4] = shifted[BIN_W + 4*k +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      work   <= work_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      result <= result_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    work_nxt   = work;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    err_nxt    = err;
    result_nxt = result;

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          if (!digits_ok(bcd_in)) begin
            // Bad digit: report immediately, keep the previous result.
            state_nxt = DONE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = SHIFT;
            work_nxt  = {bcd_in, BIN_W'(0)};
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            busy_nxt  = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_nxt = shifted;
        cnt_nxt  = cnt + CNT_W'(1);
        if (cnt == LAST_SHIFT) begin
          result_nxt = shifted[BIN_W-1:0];
          state_nxt  = DONE;
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed cases plus randomized traffic
// compared every cycle against a decimal-arithmetic reference model.
module tb_bcd_to_bin_seq;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned BIN_W = 14;
  localparam int unsigned CNT_W = 4;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic [4*NDIG-1:0]  bcd_in;
  logic               busy;
  logic               done;
  logic               err;
  logic [BIN_W-1:0]   result;

  int checks   = 0;
  int failures = 0;

  bcd_to_bin_seq #(.NDIG(NDIG), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .result  (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of a packed BCD word, or -1 if any digit is not 0..9.
  function automatic int bcd_value(input logic [4*NDIG-1:0] v);
    int val;
    int scale;
    logic [3:0] d;
    val = 0;
    scale = 1;
    for (int k = 0; k < int'(NDIG); k++) begin
      d = v[4*k +: 4];
      if (d > 4'd9) return -1;
      val += int'(d) * scale;
      scale *= 10;
    end
    return val;
  endfunction

  // Reference model: a conversion is a countdown of BIN_W cycles ending in the decimal value.
  logic m_busy, m_done, m_err;
  int   m_result, m_pending, m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_result = 0; m_pending = 0; m_left = 0;
    end else if (m_busy) begin
      m_done = 1'b0;
      m_left--;
      if (m_left == 0) begin
        m_busy   = 1'b0;
        m_done   = 1'b1;
        m_result = m_pending;
      end
    end else if (start) begin
      if (bcd_value(bcd_in) < 0) begin
        m_err  = 1'b1;
        m_done = 1'b1;
      end else begin
        m_err     = 1'b0;
        m_done    = 1'b0;
        m_busy    = 1'b1;
        m_pending = bcd_value(bcd_in);
        m_left    = BIN_W;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    chk("result", 32'(result), 32'(m_result));
    chk("busy_done_excl", 32'(busy && done), 32'd0);
  end

  // Caller is just after a rising edge; start is held over exactly one edge.
  task automatic run_conv(input logic [15:0] v, output int lat, output int busy_cyc);
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  initial begin
    int lat, bc, n_done, last_res;
    start   = 1'b0;
    bcd_in  = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Zero: done BIN_W edges after the accepting edge (BIN_W+1 cycles start-to-done).
    run_conv(16'h0000, lat, bc);
    chk("t1_latency", 32'(lat), 32'(BIN_W));
    chk("t1_result", 32'(result), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    chk("t1_done_one_cycle", 32'(done), 32'd0);

    run_conv(16'h1234, lat, bc);
    chk("t2_result", 32'(result), 32'd1234);
    chk("t2_busy_cycles", 32'(bc), 32'd14);
    @(posedge clk); #1;
    chk("t2_done_one_cycle", 32'(done), 32'd0);

    // Back-to-back: second start issued while done is high.
    run_conv(16'h9999, lat, bc);
    chk("t3_result_9999", 32'(result), 32'd9999);
    run_conv(16'h0001, lat, bc);
    chk("t3_b2b_latency", 32'(lat), 32'(BIN_W));
    chk("t3_result_1", 32'(result), 32'd1);

    repeat (2) @(posedge clk); #1;
    run_conv(16'h12A4, lat, bc);
    chk("t4_latency", 32'(lat), 32'd0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_result_held", 32'(result), 32'd1);
    run_conv(16'h0042, lat, bc);
    chk("t4_err_clear", 32'(err), 32'd0);
    chk("t4_result_42", 32'(result), 32'd42);

    // Second start while busy must be dropped.
    @(posedge clk); #1;
    start = 1'b1; bcd_in = 16'h0500;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk); #1;
    start = 1'b1; bcd_in = 16'h0777;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("t5_done_count", 32'(n_done), 32'd1);
    chk("t5_result", 32'(result), 32'd500);

    // Reset mid-conversion.
    start = 1'b1; bcd_in = 16'h8888;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("t6_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_result", 32'(result), 32'd0);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    n_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("t6_no_done", 32'(n_done), 32'd0);

    // Randomized traffic: starts arrive at any time, including during busy and done.
    n_done = 0;
    last_res = 0;
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 2) == 0);
      bcd_in = rand_bcd();
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        last_res = int'(result);
      end
    end
    start = 1'b0;
    chk("rand_enough_done", 32'(n_done > 50), 32'd1);
    chk("rand_result_range", 32'(last_res <= 9999), 32'd1);
    repeat (20) @(posedge clk);
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
